// File: rtl/psr_pkg.sv
// Shared types for the parametrised shift register: operation modes and FSM states.
package psr_pkg;

  localparam int PSR_MODE_W = 3;

  typedef enum logic [PSR_MODE_W-1:0] {
    PSR_HOLD   = 3'b000,
    PSR_LOAD   = 3'b001,
    PSR_SHL    = 3'b010,
    PSR_SHR    = 3'b011,
    PSR_ROL    = 3'b100,
    PSR_ROR    = 3'b101,
    PSR_TOGGLE = 3'b110,
    PSR_CLEAR  = 3'b111
  } psr_mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } psr_state_e;

endpackage : psr_pkg

// File: rtl/psr_next_val.sv
// Combinational next-value logic for the shift register: one step of the selected mode.
module psr_next_val
  import psr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  psr_mode_e        mode,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] data,
  input  logic             ser_in_msb,
  input  logic             ser_in_lsb,
  output logic [WIDTH-1:0] next_q
);

  always_comb begin
    // NOTE: default first so every path assigns next_q and no latch is inferred.
    next_q = q;
    case (mode)
      PSR_HOLD:   next_q = q;
      PSR_LOAD:   next_q = data;
      PSR_SHL:    next_q = {q[WIDTH-2:0], ser_in_lsb};
      PSR_SHR:    next_q = {ser_in_msb, q[WIDTH-1:1]};
      PSR_ROL:    next_q = {q[WIDTH-2:0], q[WIDTH-1]};
      PSR_ROR:    next_q = {q[0], q[WIDTH-1:1]};
      PSR_TOGGLE: next_q = q ^ data;
      PSR_CLEAR:  next_q = '0;
      default:    next_q = q;
    endcase
  end

endmodule : psr_next_val

// File: rtl/param_shift_register.sv
// WIDTH-bit register driven by a valid/ready command port; repeats one op op_cnt times, then pulses done.
// Optional parity output enabled by defining PSR_PARITY_EN; otherwise parity is tied low.
module param_shift_register
  import psr_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter int               CNT_W     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [2:0]       op_mode,
  input  logic [CNT_W-1:0] op_cnt,
  input  logic [WIDTH-1:0] op_data,
  input  logic             ser_in_msb,
  input  logic             ser_in_lsb,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_n,
  output logic             busy,
  output logic             done,
  output logic             parity
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  psr_state_e       state;
  psr_mode_e        mode_lat;
  logic [WIDTH-1:0] data_lat;
  logic [CNT_W-1:0] remaining;
  logic [WIDTH-1:0] next_q;
  logic             accept;

  // op_ready is itself a register that is 1 exactly in IDLE and DONE.
  assign accept = op_valid && op_ready;

  psr_next_val #(
    .WIDTH(WIDTH)
  ) u_next_val (
    .mode       (mode_lat),
    .q          (q),
    .data       (data_lat),
    .ser_in_msb (ser_in_msb),
    .ser_in_lsb (ser_in_lsb),
    .next_q     (next_q)
  );

  // FSM with registered busy/done/op_ready so the outputs carry no decode glitches.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      op_ready  <= 1'b1;
      mode_lat  <= PSR_HOLD;
      data_lat  <= '0;
      remaining <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            mode_lat  <= psr_mode_e'(op_mode);
            data_lat  <= op_data;
            remaining <= op_cnt;
            if (op_cnt == '0) begin
              state    <= DONE;
              done     <= 1'b1;
              busy     <= 1'b0;
              op_ready <= 1'b1;
            end else begin
              state    <= RUN;
              busy     <= 1'b1;
              op_ready <= 1'b0;
            end
          end else begin
            state    <= IDLE;
            busy     <= 1'b0;
            op_ready <= 1'b1;
          end
        end
        RUN: begin
          remaining <= remaining - CNT_ONE;
          if (remaining == CNT_ONE) begin
            state    <= DONE;
            done     <= 1'b1;
            busy     <= 1'b0;
            op_ready <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          busy     <= 1'b0;
          op_ready <= 1'b1;
        end
      endcase
    end
  end

  // The data register only moves while the FSM is applying the latched op.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= RESET_VAL;
    end else if (state == RUN) begin
      q <= next_q;
    end
  end

  assign q_n = ~q;

`ifdef PSR_PARITY_EN
  assign parity = ^q;
`else
  assign parity = 1'b0;
`endif

endmodule : param_shift_register
